// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I execute-stage ALU with handshake; optional iterative RV32M via `ALU_MULDIV_EN
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            bcond,
    output logic            illegal,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0] result_q;
    logic            bcond_q, illegal_q, accept;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic            unused_instr_bits;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] sum_ab, diff_ab, sra_ab, base_res, sc_result;
    logic            lt_s, lt_u, base_alt, sc_bcond, sc_illegal;

    assign shamt   = operand_b[SW-1:0];
    assign sum_ab  = operand_a + operand_b;
    assign diff_ab = operand_a - operand_b;
    assign sra_ab  = $signed(operand_a) >>> shamt;
    assign lt_s    = $signed(operand_a) < $signed(operand_b);
    assign lt_u    = operand_a < operand_b;
    // Register form selects SUB/SRA via funct7; immediate form only has SRAI via bit 30.
    assign base_alt = (opcode == OP_ARITH) ? funct7[5] : (funct3 == 3'b101 && instruction[30]);

    always_comb begin
        base_res = '0;
        case (funct3)
            3'b000: base_res = base_alt ? diff_ab : sum_ab;
            3'b001: base_res = operand_a << shamt;
            3'b010: base_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011: base_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100: base_res = operand_a ^ operand_b;
            3'b101: base_res = base_alt ? sra_ab : (operand_a >> shamt);
            3'b110: base_res = operand_a | operand_b;
            default: base_res = operand_a & operand_b;
        endcase
    end

    always_comb begin
        sc_result  = '0;
        sc_bcond   = 1'b0;
        sc_illegal = 1'b0;
        case (opcode)
            OP_ARITH: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    sc_result = base_res;
                else
                    sc_illegal = 1'b1;
            end
            OP_IMM:                     sc_result = base_res;
            OP_LOAD, OP_STORE, OP_JALR: sc_result = sum_ab;
            OP_BRANCH: begin
                sc_result = diff_ab;
                case (funct3)
                    3'b000:  sc_bcond = (operand_a == operand_b);
                    3'b001:  sc_bcond = (operand_a != operand_b);
                    3'b100:  sc_bcond = lt_s;
                    3'b101:  sc_bcond = !lt_s;
                    3'b110:  sc_bcond = lt_u;
                    3'b111:  sc_bcond = !lt_u;
                    default: sc_illegal = 1'b1;
                endcase
            end
            default: sc_illegal = 1'b1;
        endcase
        if (sc_illegal) begin
            sc_result = '0;
            sc_bcond  = 1'b0;
        end
    end

    logic            md_req, md_special, md_go, md_last;
    logic [XLEN-1:0] md_special_res, md_result;

`ifdef ALU_MULDIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic              is_div, div_signed, b_zero, div_ovf, a_neg, b_neg, neg_q, rneg_q;
    logic [XLEN-1:0]   mag_a, mag_b, opd_q, step_opd, quo, rem;
    logic [2*XLEN-1:0] acc_q, step_src, acc_step, prod;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2:0]        f3_q, step_f3;
    logic [SW-1:0]     cnt_q;

    assign md_req     = (opcode == OP_ARITH) && (funct7 == 7'b0000001);
    assign is_div     = funct3[2];
    assign div_signed = !funct3[0];
    assign b_zero     = (operand_b == '0);
    assign div_ovf    = div_signed && (operand_a == MOST_NEG) && (operand_b == '1);
    assign md_special = md_req && is_div && (b_zero || div_ovf);
    assign md_special_res = funct3[1] ? (b_zero ? operand_a : '0) : (b_zero ? '1 : operand_a);
    assign md_go      = md_req && !md_special;
    assign a_neg      = (is_div ? div_signed : (funct3[1:0] != 2'b11)) && operand_a[XLEN-1];
    assign b_neg      = (is_div ? div_signed : !funct3[1]) && operand_b[XLEN-1];
    assign mag_a      = a_neg ? -operand_a : operand_a;
    assign mag_b      = b_neg ? -operand_b : operand_b;

    // The first iteration runs on the accept edge so XLEN steps fit the XLEN-cycle latency.
    assign step_src  = (state_q == S_CALC) ? acc_q : {{XLEN{1'b0}}, mag_a};
    assign step_opd  = (state_q == S_CALC) ? opd_q : mag_b;
    assign step_f3   = (state_q == S_CALC) ? f3_q  : funct3;
    assign mul_sum   = {1'b0, step_src[2*XLEN-1:XLEN]} + (step_src[0] ? {1'b0, step_opd} : '0);
    assign div_trial = {step_src[2*XLEN-1:XLEN], step_src[XLEN-1]} - {1'b0, step_opd};
    assign acc_step  = !step_f3[2]      ? {mul_sum, step_src[XLEN-1:1]} :
                       div_trial[XLEN]  ? {step_src[2*XLEN-2:0], 1'b0} :
                                          {div_trial[XLEN-1:0], step_src[XLEN-2:0], 1'b1};

    assign prod = neg_q ? -acc_step : acc_step;
    assign quo  = acc_step[XLEN-1:0];
    assign rem  = acc_step[2*XLEN-1:XLEN];
    assign md_result = !f3_q[2] ? ((f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                       f3_q[1]  ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
    assign md_last = (state_q == S_CALC) && (cnt_q == SW'(XLEN-1));
    assign busy    = (state_q == S_CALC);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opd_q  <= '0;
            f3_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            cnt_q  <= '0;
        end else if (accept && md_go) begin
            acc_q  <= acc_step;
            opd_q  <= mag_b;
            f3_q   <= funct3;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= SW'(1);
        end else if (state_q == S_CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + SW'(1);
        end
    end
`else
    assign md_req         = 1'b0;
    assign md_special     = 1'b0;
    assign md_go          = 1'b0;
    assign md_last        = 1'b0;
    assign md_special_res = '0;
    assign md_result      = '0;
    assign busy           = 1'b0;
`endif

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign bcond     = bcond_q;
    assign illegal   = illegal_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = md_go ? S_CALC : S_DONE;
            S_CALC: if (md_last) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = accept ? (md_go ? S_CALC : S_DONE) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            bcond_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !md_go) begin
                result_q  <= md_special ? md_special_res : sc_result;
                bcond_q   <= sc_bcond;
                illegal_q <= sc_illegal && !md_req;
            end else if (accept) begin
                bcond_q   <= 1'b0;
                illegal_q <= 1'b0;
            end else if (md_last) begin
                result_q <= md_result;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with a behavioural reference model
module tb_alu_exec_unit;
    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam logic [6:0] ARITH = 7'b0110011, IMM = 7'b0010011, BRANCH = 7'b1100011;

    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] instruction = '0, operand_a = '0, operand_b = '0;
    logic        in_ready, out_valid, bcond, illegal, busy;
    logic [31:0] result;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .bcond(bcond), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        bc;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0, cyc = 0, last_wait = 0, ready_mode = 0;
    bit   mon_first = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 10'd0, f3, 5'd0, op};
    endfunction

    // Reference: plain 64-bit arithmetic straight from the ISA definitions.
    function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic bc, output logic ill, output int lat);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] sh;
        logic       alt;
        longint     sa, sb_, ua, ub, p;
        longint unsigned uua, uub, pu;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; sh = b[4:0];
        sa = longint'($signed(a)); sb_ = longint'($signed(b));
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        uua = {32'd0, a}; uub = {32'd0, b};
        r = '0; bc = 1'b0; ill = 1'b0; lat = 1;
        alt = (op == ARITH) ? (f7 == 7'h20) : (f3 == 3'd5 && ins[30]);
        if (op == ARITH && f7 == 7'h01) begin
            if (!MD_EN) ill = 1'b1;
            else begin
                lat = 32;
                case (f3)
                    3'd0: begin p = sa * sb_; r = p[31:0]; end
                    3'd1: begin p = sa * sb_; r = p[63:32]; end
                    3'd2: begin p = sa * ub;  r = p[63:32]; end
                    3'd3: begin pu = uua * uub; r = pu[63:32]; end
                    3'd4: if (b == 0) begin r = '1; lat = 1; end
                          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; lat = 1; end
                          else r = 32'(sa / sb_);
                    3'd5: if (b == 0) begin r = '1; lat = 1; end else r = 32'(ua / ub);
                    3'd6: if (b == 0) begin r = a; lat = 1; end
                          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = '0; lat = 1; end
                          else r = 32'(sa % sb_);
                    default: if (b == 0) begin r = a; lat = 1; end else r = 32'(ua % ub);
                endcase
            end
        end else if (op == IMM || (op == ARITH && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))) begin
            case (f3)
                3'd0: r = alt ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: r = {31'd0, sa < sb_};
                3'd3: r = {31'd0, ua < ub};
                3'd4: r = a ^ b;
                3'd5: r = alt ? 32'(sa >>> sh) : a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100111) begin
            r = a + b;
        end else if (op == BRANCH && f3 != 3'd2 && f3 != 3'd3) begin
            r = a - b;
            case (f3)
                3'd0: bc = (a == b);
                3'd1: bc = (a != b);
                3'd4: bc = (sa < sb_);
                3'd5: bc = (sa >= sb_);
                3'd6: bc = (ua < ub);
                default: bc = (ua >= ub);
            endcase
        end else begin
            ill = 1'b1;
        end
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        model(ins, a, b, e.r, e.bc, e.ill, lat);
        instruction = ins; operand_a = a; operand_b = b; in_valid = 1'b1;
        last_wait = 0;
        @(negedge clk);
        while (!in_ready && last_wait < 200) begin
            last_wait++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.due = cyc + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        ready_mode = 0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op, f7;
        logic [2:0] f3;
        int k;
        k = $urandom_range(0, 11);
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'h00;
        op = ARITH;
        case (k)
            0, 1:  f7 = 7'h00;
            2:     f7 = 7'h20;
            3, 4:  f7 = 7'h01;
            5:     f7 = 7'($urandom);
            6, 7:  begin op = IMM; f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            8:     case ($urandom_range(0, 2))
                       0: op = 7'b0000011;
                       1: op = 7'b0100011;
                       default: op = 7'b1100111;
                   endcase
            9, 10: op = BRANCH;
            default: op = 7'($urandom);
        endcase
        return {f7, 10'($urandom), f3, 5'($urandom), op};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every valid cycle is compared against the head, so held outputs are checked too.
    initial forever begin
        @(negedge clk);
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                if (mon_first) begin
                    chk("latency", cyc, sb[0].due);
                    mon_first = 1'b0;
                end
                chk("result", result, sb[0].r);
                chk("bcond", 32'(bcond), 32'(sb[0].bc));
                chk("illegal", 32'(illegal), 32'(sb[0].ill));
                if (out_ready) begin
                    void'(sb.pop_front());
                    mon_first = 1'b1;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_bcond", 32'(bcond), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(enc(ARITH, 3'd0, 7'h00), 32'h7FFFFFFF, 32'h1);
        issue(enc(ARITH, 3'd5, 7'h20), 32'h80000000, 32'h4);
        chk("b2b_wait", last_wait, 0);
        issue(enc(BRANCH, 3'd6, 7'h00), 32'h1, 32'hFFFFFFFF);
        issue(enc(BRANCH, 3'd4, 7'h00), 32'h1, 32'hFFFFFFFF);
        issue(enc(7'h7F, 3'd0, 7'h00), 32'h1234, 32'h5678);
        issue(enc(ARITH, 3'd0, 7'h01), 32'h3, 32'h5);
        drain();

        ready_mode = 2;
        issue(enc(ARITH, 3'd4, 7'h00), 32'hA5A5A5A5, 32'h0F0F0F0F);
        repeat (3) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        issue(enc(IMM, 3'd2, 7'h00), 32'hFFFFFFFE, 32'h1);
        chk("release_accept_wait", last_wait, 0);
        drain();

`ifdef ALU_MULDIV_EN
        issue(enc(ARITH, 3'd1, 7'h01), 32'h80000000, 32'h80000000);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) cnt++;
        end
        chk("mulh_busy_cycles", cnt, XLEN - 1);
        issue(enc(ARITH, 3'd4, 7'h01), 32'd7, 32'd0);
        issue(enc(ARITH, 3'd6, 7'h01), 32'h80000000, 32'hFFFFFFFF);
        drain();
`endif

        issue(enc(ARITH, 3'd4, 7'h01), 32'd100, 32'd7);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        mon_first = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abort_no_out_valid", cnt, 0);
        @(posedge clk);
        #1;
        issue(enc(ARITH, 3'd0, 7'h00), 32'd20, 32'd22);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 250; i++) begin
            issue(rand_instr(), rand_operand(), rand_operand());
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
